wrr_arbiter: RTL and testbench
==============================

WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, legal range 2..16.
REQ-002 Parameter WEIGHT_W, default 4: width of each requester weight field.
REQ-003 Parameter TIMEOUT_CYC, default 256: BUSY-cycle limit before forced release; used only when WRR_ARB_TIMEOUT_EN is defined.
REQ-004 The port list SHALL be as follows, one port per line (name, direction, width, meaning):
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_i  input  N_REQ  per-requester request, level.
- weight_i  input  N_REQ*WEIGHT_W  per-requester weight; field k is bits [k*WEIGHT_W +: WEIGHT_W].
- ack_i  input  1  granted requester has completed one transaction.
- grant_o  output  N_REQ  registered one-hot grant.
- grant_idx_o  output  $clog2(N_REQ)  binary index of the granted requester.
- grant_valid_o  output  1  high when grant_o is non-zero.
- timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-005 Two-state FSM, IDLE and BUSY; all outputs registered; no combinational path from req_i or ack_i to any output.
REQ-006 In IDLE with |req_i=1: select the lowest-index request at or above ptr_q; if none exists there, wrap and take the lowest-index request overall.
REQ-007 The selection in REQ-006 SHALL load grant_o, grant_idx_o and grant_valid_o=1 on the next clock edge and move the FSM to BUSY (req-to-grant latency = 1 cycle).
REQ-008 In IDLE with req_i=0: remain IDLE with grant_o=0 and grant_valid_o=0; ack_i is ignored in IDLE.
REQ-009 On entry to BUSY, credit_q SHALL load the granted requester's weight_i field; a weight of 0 is treated as 1.
REQ-010 In BUSY, the grant SHALL be held until release, regardless of changes on req_i or weight_i.
REQ-011 In BUSY, ack_i=1 with credit_q>1 and the granted req_i bit still high: decrement credit_q, keep the grant unchanged, stay BUSY (back-to-back service, zero bubble).
REQ-012 In BUSY, ack_i=1 with credit_q==1 or the granted req_i bit low: release.
REQ-013 Release SHALL set ptr_q to (grant_idx+1) mod N_REQ, clear grant_o and grant_valid_o, and move to IDLE; the next grant appears no earlier than 2 cycles after the releasing ack.
REQ-014 Pointer wrap: releasing index N_REQ-1 SHALL set ptr_q to 0.
REQ-015 A requester with pending req SHALL wait at most sum over other requesters of (weight or 1) transactions before being granted (no starvation).
REQ-016 grant_idx_o SHALL always equal the encoded index of grant_o; it is 0 when grant_valid_o=0.

Reset
REQ-017 rst_n low SHALL asynchronously force state=IDLE, grant_o=0, grant_idx_o=0, grant_valid_o=0, timeout_o=0, ptr_q=0, credit_q=0.
REQ-018 Reset asserted mid-BUSY SHALL abandon the grant with no ack required; after deassertion, arbitration restarts from index 0.
REQ-019 Reset deassertion is synchronised externally; the first edge after deassertion MAY grant.

Configuration
REQ-020 Macro WRR_ARB_TIMEOUT_EN defined: hold_cnt_q counts cycles spent in BUSY and clears on every ack_i.
REQ-021 With the macro defined, reaching TIMEOUT_CYC SHALL perform a release per REQ-013 and pulse timeout_o for 1 cycle; ack_i arriving in the same cycle takes precedence, with no timeout_o pulse.
REQ-022 Macro WRR_ARB_TIMEOUT_EN undefined: no hold counter is instantiated, timeout_o is tied 0, and the grant is held indefinitely until ack_i.

Verification
REQ-023 N_REQ=4, all weights=1, req_i=4'b1111 constant, ack every BUSY cycle -> grant sequence 0,1,2,3,0 with grant_o one-hot and an IDLE gap of 1 cycle between grants.
REQ-024 weights {3,1,1,1} (idx0=3), req_i=4'b0011 constant, ack each cycle -> idx0 served for 3 consecutive acks, then idx1 for 1, then idx0 for 3 again.
REQ-025 idx2 granted with weight 4; drop req_i[2] before the 2nd ack -> release on that ack, ptr_q=3, next grant goes to idx3 if requesting.
REQ-026 ptr_q=3, req_i=4'b0101 -> wrap, grant idx0; weight_i field=0 -> exactly one transaction, then release.
REQ-027 Assert rst_n=0 mid-BUSY with idx2 granted -> grant_o=0 and grant_valid_o=0 immediately (asynchronously); after release of reset with req_i=4'b1111 -> grant idx0.
REQ-028 WRR_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no ack -> release after 8 BUSY cycles with a 1-cycle timeout_o pulse; ack on cycle 8 -> no pulse.

Source files
------------

// File: rtl/wrr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wrr_arbiter_if                                         |
// | Description : Request/weight/ack and grant bundle for wrr_arbiter.   |
// |               The slave modport is the arbiter side. The master      |
// |               modport is the requester/agent side.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface wrr_arbiter_if #(
  parameter int N_REQ    = 4,
  parameter int WEIGHT_W = 4
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]          req_i;
  logic [N_REQ*WEIGHT_W-1:0] weight_i;
  logic                      ack_i;
  logic [N_REQ-1:0]          grant_o;
  logic [IDX_W-1:0]          grant_idx_o;
  logic                      grant_valid_o;
  logic                      timeout_o;

  modport slave (
    input  req_i, weight_i, ack_i,
    output grant_o, grant_idx_o, grant_valid_o, timeout_o
  );

  modport master (
    output req_i, weight_i, ack_i,
    input  grant_o, grant_idx_o, grant_valid_o, timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wrr_arbiter                                            |
// | Description : Weighted round-robin arbiter. A winner keeps the grant |
// |               for up to max(weight,1) back-to-back transactions.     |
// |               Rotation then resumes from the index after the winner. |
// |               Optional macro WRR_ARB_TIMEOUT_EN adds a hold-cycle    |
// |               watchdog that force-releases a stuck grant.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wrr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WEIGHT_W    = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  wire              clk,
  input  wire              rst_n,
  wrr_arbiter_if.slave     bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [WEIGHT_W-1:0] c_credit_one = {{(WEIGHT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]    c_last_idx   = IDX_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [N_REQ-1:0]    r_grant, w_grant_nxt;
  logic [IDX_W-1:0]    r_grant_idx, w_grant_idx_nxt;
  logic                r_grant_valid, w_grant_valid_nxt;
  logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
  logic [WEIGHT_W-1:0] r_credit, w_credit_nxt;

  logic                w_hi_found, w_lo_found;
  logic [IDX_W-1:0]    w_hi_idx, w_lo_idx, w_sel_idx;
  logic [WEIGHT_W-1:0] w_sel_weight;
  logic                w_release;

`ifdef WRR_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(TIMEOUT_CYC - 1);

  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic                r_timeout, w_timeout_nxt;
`else
  logic                w_unused_timeout_cfg;
`endif

  // Find the lowest requester at/above the pointer and the lowest overall;
  // the descending scan leaves the lowest matching index in each result.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = IDX_W'(i);
        if (IDX_W'(i) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(i);
        end
      end
    end
  end

  // Winner is the first request after the pointer, wrapping to the lowest.
  // A zero weight still buys the winner one transaction.
  always_comb begin
    w_sel_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
    w_sel_weight = bus.weight_i[w_sel_idx*WEIGHT_W +: WEIGHT_W];
    if (w_sel_weight == '0) begin
      w_sel_weight = c_credit_one;
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = r_grant_valid;
    w_ptr_nxt         = r_ptr;
    w_credit_nxt      = r_credit;
    w_release         = 1'b0;
`ifdef WRR_ARB_TIMEOUT_EN
    w_hold_cnt_nxt    = r_hold_cnt;
    w_timeout_nxt     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_lo_found) begin
          w_state_nxt       = S_BUSY;
          w_grant_nxt       = N_REQ'(1) << w_sel_idx;
          w_grant_idx_nxt   = w_sel_idx;
          w_grant_valid_nxt = 1'b1;
          w_credit_nxt      = w_sel_weight;
`ifdef WRR_ARB_TIMEOUT_EN
          w_hold_cnt_nxt    = '0;
`endif
        end
      end
      S_BUSY: begin
        if (bus.ack_i) begin
`ifdef WRR_ARB_TIMEOUT_EN
          w_hold_cnt_nxt = '0;
`endif
          // Keep serving only while credit remains and the owner still asks.
          if ((r_credit > c_credit_one) && bus.req_i[r_grant_idx]) begin
            w_credit_nxt = r_credit - c_credit_one;
          end else begin
            w_release = 1'b1;
          end
        end
`ifdef WRR_ARB_TIMEOUT_EN
        else if (r_hold_cnt == c_hold_last) begin
          w_release     = 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
`endif
        if (w_release) begin
          w_state_nxt       = S_IDLE;
          w_grant_nxt       = '0;
          w_grant_idx_nxt   = '0;
          w_grant_valid_nxt = 1'b0;
          w_ptr_nxt         = (r_grant_idx == c_last_idx) ? '0 : r_grant_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt       = S_IDLE;
        w_grant_nxt       = '0;
        w_grant_idx_nxt   = '0;
        w_grant_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= '0;
      r_credit      <= '0;
`ifdef WRR_ARB_TIMEOUT_EN
      r_hold_cnt    <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_ptr         <= w_ptr_nxt;
      r_credit      <= w_credit_nxt;
`ifdef WRR_ARB_TIMEOUT_EN
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_timeout     <= w_timeout_nxt;
`endif
    end
  end

  assign bus.grant_o       = r_grant;
  assign bus.grant_idx_o   = r_grant_idx;
  assign bus.grant_valid_o = r_grant_valid;
`ifdef WRR_ARB_TIMEOUT_EN
  assign bus.timeout_o     = r_timeout;
`else
  // Without the watchdog a grant is only ever released by ack.
  assign bus.timeout_o        = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_wrr_arbiter                                         |
// | Description : Self-checking bench for wrr_arbiter. It runs directed  |
// |               scenarios and a randomized run. Results are checked    |
// |               against a rotating-search reference model.             |
// |               Define WRR_ARB_TIMEOUT_EN to also check the watchdog.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_wrr_arbiter;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wrr_arbiter_if #(.N_REQ(N), .WEIGHT_W(WW)) bus ();

  wrr_arbiter #(.N_REQ(N), .WEIGHT_W(WW), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current owner (-1 = none), transactions left, pointer.
  int m_owner, m_rem, m_ptr, m_hold;
  bit m_tmo;
  logic [N-1:0] exp_grant;
  logic [1:0]   exp_idx;
  logic         exp_valid;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int eff_weight(int i);
    int v;
    v = int'(bus.weight_i[i*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rem = 0; m_ptr = 0; m_hold = 0; m_tmo = 1'b0;
    exp_grant = '0; exp_idx = '0; exp_valid = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic step();
    int p;
    @(posedge clk);
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      p = pick(bus.req_i, m_ptr);
      if (p >= 0) begin
        m_owner = p; m_rem = eff_weight(p); m_hold = 0;
      end
    end else if (bus.ack_i) begin
      m_hold = 0;
      if (m_rem > 1 && bus.req_i[m_owner]) m_rem--;
      else begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
    end else begin
      m_hold++;
`ifdef WRR_ARB_TIMEOUT_EN
      if (m_hold == TO) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_tmo = 1'b1;
      end
`endif
    end
    exp_valid = (m_owner >= 0);
    exp_grant = exp_valid ? (N'(1) << m_owner) : '0;
    exp_idx   = exp_valid ? 2'(m_owner) : 2'd0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_i = '0; bus.weight_i = '0; bus.ack_i = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_i = 4'b1111; bus.weight_i = 16'h1111; bus.ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.grant_o !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b want 0000", bus.grant_o); end
    n_vec++; if (bus.grant_idx_o !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", bus.grant_idx_o); end
    n_vec++; if (bus.grant_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.grant_valid_o); end
    n_vec++; if (bus.timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", bus.timeout_o); end
  endtask

  // All weights 1, everyone requesting, ack always: 0,1,2,3,0 with 1-cycle gaps.
  task automatic test_round_robin();
    logic [N-1:0] want_g;
    do_reset();
    bus.weight_i = 16'h1111; bus.req_i = 4'b1111; bus.ack_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      want_g = (c % 2 == 0) ? (N'(1) << ((c / 2) % 4)) : '0;
      n_vec++; if (bus.grant_o !== want_g) begin n_err++; $display("FAIL rr_grant cyc %0d got %b want %b", c, bus.grant_o, want_g); end
      n_vec++; if (bus.grant_idx_o !== ((c % 2 == 0) ? 2'((c / 2) % 4) : 2'd0)) begin n_err++; $display("FAIL rr_idx cyc %0d got %0d", c, bus.grant_idx_o); end
      n_vec++; if (bus.grant_valid_o !== (c % 2 == 0)) begin n_err++; $display("FAIL rr_valid cyc %0d got %b", c, bus.grant_valid_o); end
    end
  endtask

  // Weights {idx0=3, others 1}, req 0011: idx0 x3, idx1 x1, idx0 x3.
  task automatic test_weighted();
    bit v_tab[10] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 0};
    int i_tab[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    do_reset();
    bus.weight_i = 16'h1113; bus.req_i = 4'b0011; bus.ack_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      n_vec++; if (bus.grant_valid_o !== v_tab[c]) begin n_err++; $display("FAIL wt_valid cyc %0d got %b want %b", c, bus.grant_valid_o, v_tab[c]); end
      n_vec++; if (bus.grant_idx_o !== 2'(i_tab[c])) begin n_err++; $display("FAIL wt_idx cyc %0d got %0d want %0d", c, bus.grant_idx_o, i_tab[c]); end
    end
  endtask

  // idx2 with weight 4 drops its request before the 2nd ack; next goes to idx3.
  task automatic test_drop_req();
    logic [3:0] r_tab[4] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000};
    bit a_tab[4] = '{0, 1, 1, 0};
    bit v_tab[4] = '{1, 1, 0, 1};
    int i_tab[4] = '{2, 2, 0, 3};
    do_reset();
    bus.weight_i = 16'h0400;
    for (int c = 0; c < 4; c++) begin
      bus.req_i = r_tab[c]; bus.ack_i = a_tab[c];
      step();
      n_vec++; if (bus.grant_valid_o !== v_tab[c]) begin n_err++; $display("FAIL drop_valid step %0d got %b want %b", c, bus.grant_valid_o, v_tab[c]); end
      n_vec++; if (bus.grant_idx_o !== 2'(i_tab[c])) begin n_err++; $display("FAIL drop_idx step %0d got %0d want %0d", c, bus.grant_idx_o, i_tab[c]); end
    end
  endtask

  // Pointer at 3 with req 0101 wraps to idx0, whose zero weight gives one transaction.
  task automatic test_wrap_zero_weight();
    logic [3:0] r_tab[5] = '{4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0101};
    bit a_tab[5] = '{0, 1, 0, 1, 0};
    bit v_tab[5] = '{1, 0, 1, 0, 1};
    int i_tab[5] = '{2, 0, 0, 0, 2};
    do_reset();
    bus.weight_i = 16'h0100;
    for (int c = 0; c < 5; c++) begin
      bus.req_i = r_tab[c]; bus.ack_i = a_tab[c];
      step();
      n_vec++; if (bus.grant_valid_o !== v_tab[c]) begin n_err++; $display("FAIL wrap_valid step %0d got %b want %b", c, bus.grant_valid_o, v_tab[c]); end
      n_vec++; if (bus.grant_idx_o !== 2'(i_tab[c])) begin n_err++; $display("FAIL wrap_idx step %0d got %0d want %0d", c, bus.grant_idx_o, i_tab[c]); end
    end
  endtask

  // Reset while idx2 is granted must drop the grant with no clock edge.
  task automatic test_reset_mid_busy();
    do_reset();
    bus.weight_i = 16'h0400; bus.req_i = 4'b0100; bus.ack_i = 1'b0;
    step();
    n_vec++; if (bus.grant_o !== 4'b0100) begin n_err++; $display("FAIL rmb_pre got %b want 0100", bus.grant_o); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.grant_o !== 4'b0000) begin n_err++; $display("FAIL rmb_async_grant got %b want 0000", bus.grant_o); end
    n_vec++; if (bus.grant_valid_o !== 1'b0) begin n_err++; $display("FAIL rmb_async_valid got %b want 0", bus.grant_valid_o); end
    n_vec++; if (bus.grant_idx_o !== 2'd0) begin n_err++; $display("FAIL rmb_async_idx got %0d want 0", bus.grant_idx_o); end
    model_reset();
    bus.req_i = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_vec++; if (bus.grant_o !== 4'b0001) begin n_err++; $display("FAIL rmb_restart got %b want 0001", bus.grant_o); end
  endtask

  // Random traffic, weights changing under the grant, against the model.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req_i    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15) | 4'b0011);
      bus.weight_i = 16'($urandom);
      bus.ack_i    = ($urandom_range(0, 3) != 0);
      step();
      n_vec++; if (bus.grant_o !== exp_grant) begin n_err++; $display("FAIL rnd_grant cyc %0d got %b want %b", c, bus.grant_o, exp_grant); end
      n_vec++; if (bus.grant_idx_o !== exp_idx) begin n_err++; $display("FAIL rnd_idx cyc %0d got %0d want %0d", c, bus.grant_idx_o, exp_idx); end
      n_vec++; if (bus.grant_valid_o !== exp_valid) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, bus.grant_valid_o, exp_valid); end
      n_vec++; if (bus.timeout_o !== m_tmo) begin n_err++; $display("FAIL rnd_timeout cyc %0d got %b want %b", c, bus.timeout_o, m_tmo); end
    end
  endtask

`ifdef WRR_ARB_TIMEOUT_EN
  // No ack: release after 8 BUSY cycles with a pulse; ack on cycle 8: no pulse.
  task automatic test_timeout();
    do_reset();
    bus.weight_i = 16'h1111; bus.req_i = 4'b0001; bus.ack_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      n_vec++; if (bus.grant_valid_o !== 1'b1 || bus.timeout_o !== 1'b0) begin n_err++; $display("FAIL to_hold cyc %0d got v=%b t=%b want v=1 t=0", c, bus.grant_valid_o, bus.timeout_o); end
    end
    step();
    n_vec++; if (bus.grant_valid_o !== 1'b0 || bus.timeout_o !== 1'b1) begin n_err++; $display("FAIL to_fire got v=%b t=%b want v=0 t=1", bus.grant_valid_o, bus.timeout_o); end
    for (int c = 0; c < 8; c++) begin
      step();
      n_vec++; if (bus.grant_valid_o !== 1'b1 || bus.timeout_o !== 1'b0) begin n_err++; $display("FAIL to_regrant cyc %0d got v=%b t=%b want v=1 t=0", c, bus.grant_valid_o, bus.timeout_o); end
    end
    bus.ack_i = 1'b1;
    step();
    n_vec++; if (bus.grant_valid_o !== 1'b0 || bus.timeout_o !== 1'b0) begin n_err++; $display("FAIL to_ack_wins got v=%b t=%b want v=0 t=0", bus.grant_valid_o, bus.timeout_o); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_weighted();
    test_drop_req();
    test_wrap_zero_weight();
    test_reset_mid_busy();
    test_random();
`ifdef WRR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
